logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Parametrised multi-cycle logic/bit-manipulation unit for the RV052B execute stage: successor of the fixed 32-bit `LOGIC` unit. Adds configurable data width, a step size that bounds per-cycle hardware, iterative count ops (CLZ/CTZ/CPOP) and shift/rotate ops with operand-dependent latency. It keeps the start/done handshake so the issue logic drives it like the existing unit.

## Interface

- `XLEN`, 32: operand/result width; power of two, 16..64.
- `STEP`, 8: bits processed per RUN cycle for count and shift ops; power of two, divides `XLEN`, 1..`XLEN`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op1`  in  `XLEN`  operand 1; captured on the accepting edge.
- `op2`  in  `XLEN`  operand 2, or shift amount in `op2[log2(XLEN)-1:0]`; captured on the accepting edge.
- `op_sel`  in  4  operation code; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `res`/`err` valid from this cycle.
- `res`  out  `XLEN`  result; holds until the next completion.
- `err`  out  1  reserved opcode flag; valid with `done`, held like `res`.

## Operation

- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 ANDN (`op1 & ~op2`), 4 ORN, 5 XNOR.
  - 6 CLZ, 7 CTZ, 8 CPOP on `op1`.
  - 9 SLL, 10 SRL, 11 SRA, 12 ROL, 13 ROR of `op1` by `sh = op2[log2(XLEN)-1:0]`.
  - 14, 15 reserved.
- States:
  - IDLE -> RUN on `start`.
  - RUN -> DONE after L RUN cycles.
  - DONE -> RUN if `start`, else IDLE.
- Operands and opcode are latched on the accepting edge. Input changes afterwards have no effect.
- RUN length L:
  - Logic ops: 1.
  - Count ops: `XLEN/STEP`, fixed, with no early exit.
  - Shift/rotate ops: `max(1, ceil(sh/STEP))`. Each RUN cycle shifts by `min(remaining, STEP)`.
  - Reserved opcodes: 1.
- Count ops scan `STEP`-bit chunks. CLZ scans MSB-first, CTZ and CPOP scan LSB-first. The accumulator is `log2(XLEN)+1` bits, zero-extended into `res`. CLZ(0) = CTZ(0) = `XLEN`.
- SRA fills with the captured `op1[XLEN-1]`. Rotates wrap bits around. `sh = 0` gives `res = op1` with L=1.
- Reserved opcode: `res = 0`, `err = 1`. For every other opcode, `err = 0`.
- `start` during RUN is ignored and not queued.

## Timing

- Reset (any time, including mid-RUN): state IDLE, `busy=0`, `done=0`, `res=0`, `err=0`, counters and accumulators cleared. The in-flight operation is discarded with no `done`.
- Edge E0 accepts `start`. `busy` is high for the L cycles after E0. `done` is high in the cycle after the last RUN cycle, i.e. L+1 cycles after E0.
- `res` and `err` update on the same edge that raises `done`. They are stable at all other times.
- Back-to-back: `start` high in the DONE cycle is accepted. `busy` rises the next cycle with no IDLE bubble, so throughput is one op per L+1 cycles.
- `busy` and `done` are never high together.

## Test plan

- XLEN=32, STEP=8. AND `op1=AAAA_AAAA`, `op2=FFFF_FFFF`: `busy` high 1 cycle, `done` 2 cycles after E0, `res=AAAA_AAAA`, `err=0`. Repeat ANDN with the same operands: `res=0000_0000`. Repeat XNOR: `res=AAAA_AAAA`.
- CLZ `op1=0000_1000`: `busy` high 4 cycles, `res=19`. CLZ `0`: `res=32`. CTZ `8000_0000`: `res=31`. CPOP `FFFF_FFFF`: `res=32`.
- SRA `op1=8000_0000`, `sh=20`: L=3, `res=FFFF_F800`. ROR `op1=0000_00F1`, `sh=4`: L=1, `res=1000_000F`. SLL with `sh=0`: L=1, `res=op1`. SLL `0000_0001`, `sh=31`: L=4, `res=8000_0000`.
- Hold `start` high through a CPOP while changing `op1` mid-RUN: exactly one op is accepted per DONE/IDLE, each result matches its captured operands, and the next op starts with no IDLE cycle.
- Assert `rst=0` in the 2nd RUN cycle of a CLZ: all outputs are 0 immediately. No `done` follows. After release, an XOR `F0F0_F0F0 ^ FFFF_0000` gives `0F0F_F0F0`.
- Opcode 14: `done` after L=1, `res=0`, `err=1`. The next valid op clears `err`.

Source files
------------

// File: rtl/logic_unit_seq.sv
// Multi-cycle logic / bit-manipulation unit with a start/done handshake.
// Logic ops finish in one RUN cycle. Count ops scan STEP-bit chunks over
// XLEN/STEP cycles. Shift and rotate ops move by at most STEP bits per cycle.
module logic_unit_seq #(
   parameter int XLEN = 32,
   parameter int STEP = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [3:0]      op_sel,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] res,
   output logic            err
);

   localparam int SW     = $clog2(XLEN);
   localparam int AW     = SW + 1;
   localparam int NCHUNK = XLEN / STEP;

   localparam logic [AW-1:0] STEP_A = AW'(STEP);
   localparam logic [AW-1:0] XLEN_A = AW'(XLEN);
   localparam logic [AW-1:0] ONE_A  = AW'(1);
   localparam logic [SW-1:0] LAST_C = SW'(NCHUNK - 1);
   localparam logic [SW-1:0] ONE_S  = SW'(1);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_ANDN = 4'd3;
   localparam logic [3:0] OP_ORN  = 4'd4;
   localparam logic [3:0] OP_XNOR = 4'd5;
   localparam logic [3:0] OP_CLZ  = 4'd6;
   localparam logic [3:0] OP_CTZ  = 4'd7;
   localparam logic [3:0] OP_CPOP = 4'd8;
   localparam logic [3:0] OP_SLL  = 4'd9;
   localparam logic [3:0] OP_SRL  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_ROL  = 4'd12;
   localparam logic [3:0] OP_ROR  = 4'd13;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_n;
   logic [3:0]      op_q;
   logic [XLEN-1:0] work, opb;
   logic [SW-1:0]   rem, cnt;
   logic [AW-1:0]   acc;
   logic            found;

   logic [XLEN-1:0] work_n, result;
   logic [SW-1:0]   rem_n, amt;
   logic [AW-1:0]   acc_n, part, ramt;
   logic [STEP-1:0] hi_chunk, lo_chunk;
   logic            found_n, last, rerr, last_sh, accept;

   function automatic logic [AW-1:0] lead_zeros(input logic [STEP-1:0] c);
      logic [AW-1:0] n;
      logic          hit;
      n   = '0;
      hit = 1'b0;
      for (int i = STEP - 1; i >= 0; i--) begin
         if (c[i]) hit = 1'b1;
         else if (!hit) n = n + ONE_A;
      end
      return n;
   endfunction

   function automatic logic [AW-1:0] trail_zeros(input logic [STEP-1:0] c);
      logic [AW-1:0] n;
      logic          hit;
      n   = '0;
      hit = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         if (c[i]) hit = 1'b1;
         else if (!hit) n = n + ONE_A;
      end
      return n;
   endfunction

   function automatic logic [AW-1:0] pop_count(input logic [STEP-1:0] c);
      logic [AW-1:0] n;
      n = '0;
      for (int i = 0; i < STEP; i++) n = n + {{(AW-1){1'b0}}, c[i]};
      return n;
   endfunction

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Next-state logic: RUN lasts until the datapath flags its final cycle.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last) state_n = DONE;
         DONE:    state_n = start ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // One RUN step of the latched operation; result is only used on the last step.
   always_comb begin
      work_n   = work;
      rem_n    = rem;
      acc_n    = acc;
      found_n  = found;
      result   = '0;
      rerr     = 1'b0;
      last     = 1'b1;
      part     = '0;
      hi_chunk = work[XLEN-1 -: STEP];
      lo_chunk = work[STEP-1:0];
      // Final shift step is the one whose remaining distance fits in STEP.
      last_sh  = ({1'b0, rem} <= STEP_A);
      amt      = last_sh ? rem : STEP_A[SW-1:0];
      ramt     = XLEN_A - {1'b0, amt};
      case (op_q)
         OP_AND:  result = work & opb;
         OP_OR:   result = work | opb;
         OP_XOR:  result = work ^ opb;
         OP_ANDN: result = work & ~opb;
         OP_ORN:  result = work | ~opb;
         OP_XNOR: result = ~(work ^ opb);
         OP_CLZ: begin
            part    = lead_zeros(hi_chunk);
            work_n  = work << STEP;
            // Stop accumulating once a set bit has been seen in an earlier chunk.
            if (!found) acc_n = acc + part;
            found_n = found | (part != STEP_A);
            last    = (cnt == LAST_C);
            result  = {{(XLEN-AW){1'b0}}, acc_n};
         end
         OP_CTZ: begin
            part    = trail_zeros(lo_chunk);
            work_n  = work >> STEP;
            if (!found) acc_n = acc + part;
            found_n = found | (part != STEP_A);
            last    = (cnt == LAST_C);
            result  = {{(XLEN-AW){1'b0}}, acc_n};
         end
         OP_CPOP: begin
            part   = pop_count(lo_chunk);
            work_n = work >> STEP;
            acc_n  = acc + part;
            last   = (cnt == LAST_C);
            result = {{(XLEN-AW){1'b0}}, acc_n};
         end
         OP_SLL: begin
            work_n = work << amt;
            rem_n  = rem - amt;
            last   = last_sh;
            result = work_n;
         end
         OP_SRL: begin
            work_n = work >> amt;
            rem_n  = rem - amt;
            last   = last_sh;
            result = work_n;
         end
         OP_SRA: begin
            // The sign bit never moves, so every step refills with the captured MSB.
            work_n = $signed(work) >>> amt;
            rem_n  = rem - amt;
            last   = last_sh;
            result = work_n;
         end
         OP_ROL: begin
            work_n = (work << amt) | (work >> ramt);
            rem_n  = rem - amt;
            last   = last_sh;
            result = work_n;
         end
         OP_ROR: begin
            work_n = (work >> amt) | (work << ramt);
            rem_n  = rem - amt;
            last   = last_sh;
            result = work_n;
         end
         default: begin
            result = '0;
            rerr   = 1'b1;
         end
      endcase
   end

   // Operand capture on accept, per-cycle working state in RUN, result on the last step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q  <= '0;
         work  <= '0;
         opb   <= '0;
         rem   <= '0;
         cnt   <= '0;
         acc   <= '0;
         found <= 1'b0;
         res   <= '0;
         err   <= 1'b0;
      end else if (accept) begin
         op_q  <= op_sel;
         work  <= op1;
         opb   <= op2;
         rem   <= op2[SW-1:0];
         cnt   <= '0;
         acc   <= '0;
         found <= 1'b0;
      end else if (state == RUN) begin
         work  <= work_n;
         rem   <= rem_n;
         acc   <= acc_n;
         found <= found_n;
         cnt   <= cnt + ONE_S;
         if (last) begin
            res <= result;
            err <= rerr;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq (XLEN=32, STEP=8).
module tb_logic_unit_seq;

   logic        clk, rst, start, busy, done, err;
   logic [31:0] op1, op2, res;
   logic [3:0]  op_sel;
   int          checks = 0;
   int          passes = 0;

   logic_unit_seq #(.XLEN(32), .STEP(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
      .op_sel(op_sel), .busy(busy), .done(done), .res(res), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Issue one op from IDLE, scramble inputs after acceptance, then check
   // RUN length, overlap, result, error flag and the single-cycle done pulse.
   task automatic op_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_l, input logic [31:0] exp_res,
                         input logic exp_err);
      int   nb;
      logic seen, overlap;
      nb = 0; seen = 1'b0; overlap = 1'b0;
      op_sel = op; op1 = a; op2 = b; start = 1'b1;
      tick();
      start = 1'b0; op1 = ~a; op2 = ~b; op_sel = 4'hF;
      for (int i = 0; i < 64; i++) begin
         if (busy && done) overlap = 1'b1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nb++;
         tick();
      end
      chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({tag, "_run_len"}, nb, exp_l);
      chk({tag, "_overlap"}, {31'd0, overlap}, 32'd0);
      chk({tag, "_res"}, res, exp_res);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      tick();
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_res_hold"}, res, exp_res);
   endtask

   initial begin
      int ndone;
      rst = 1'b0; start = 1'b0; op1 = '0; op2 = '0; op_sel = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_res", res, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b1;
      tick();

      // Logic ops
      op_run("and",  4'd0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 32'hAAAA_AAAA, 1'b0);
      op_run("andn", 4'd3, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0);
      op_run("xnor", 4'd5, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 32'hAAAA_AAAA, 1'b0);
      op_run("orn",  4'd4, 32'h0000_FFFF, 32'h00FF_00FF, 1, 32'hFF00_FFFF, 1'b0);
      op_run("or",   4'd1, 32'h1200_0034, 32'h0056_7800, 1, 32'h1256_7834, 1'b0);

      // Count ops
      op_run("clz",    4'd6, 32'h0000_1000, 32'h0, 4, 32'd19, 1'b0);
      op_run("clz0",   4'd6, 32'h0000_0000, 32'h0, 4, 32'd32, 1'b0);
      op_run("ctz",    4'd7, 32'h8000_0000, 32'h0, 4, 32'd31, 1'b0);
      op_run("ctz0",   4'd7, 32'h0000_0000, 32'h0, 4, 32'd32, 1'b0);
      op_run("cpop",   4'd8, 32'hFFFF_FFFF, 32'h0, 4, 32'd32, 1'b0);
      op_run("cpop9",  4'd8, 32'h0F0F_0001, 32'h0, 4, 32'd9,  1'b0);

      // Shifts and rotates
      op_run("sra20",  4'd11, 32'h8000_0000, 32'd20, 3, 32'hFFFF_F800, 1'b0);
      op_run("ror4",   4'd13, 32'h0000_00F1, 32'd4,  1, 32'h1000_000F, 1'b0);
      op_run("sll0",   4'd9,  32'h1234_5678, 32'd0,  1, 32'h1234_5678, 1'b0);
      op_run("sll31",  4'd9,  32'h0000_0001, 32'd31, 4, 32'h8000_0000, 1'b0);
      op_run("srl9",   4'd10, 32'hF000_0000, 32'd9,  2, 32'h0078_0000, 1'b0);
      op_run("rol1",   4'd12, 32'h8000_0001, 32'hFFFF_FFE1, 1, 32'h0000_0003, 1'b0);

      // Back-to-back with start held high and op1 changing mid-RUN
      op_sel = 4'd8; op1 = 32'hFFFF_FFFF; start = 1'b1;
      tick();
      op1 = 32'h0000_000F;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_a_busy", {31'd0, busy}, 32'd1);
         tick();
      end
      chk("b2b_a_done", {31'd0, done}, 32'd1);
      chk("b2b_a_res", res, 32'd32);
      tick();
      chk("b2b_no_bubble", {31'd0, busy}, 32'd1);
      chk("b2b_b_nodone", {31'd0, done}, 32'd0);
      start = 1'b0; op1 = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b2b_b_busy", {31'd0, busy}, 32'd1);
      end
      tick();
      chk("b2b_b_done", {31'd0, done}, 32'd1);
      chk("b2b_b_res", res, 32'd4);
      tick();
      chk("b2b_idle", {31'd0, busy | done}, 32'd0);

      // Reset in the second RUN cycle of a CLZ
      op_sel = 4'd6; op1 = 32'h0000_0000; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_res", res, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) ndone++;
         tick();
      end
      chk("mid_rst_quiet", ndone, 32'd0);
      op_run("xor", 4'd2, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'h0F0F_F0F0, 1'b0);

      // Reserved opcode, then a valid op clears err
      op_run("rsv14", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0, 1'b1);
      op_run("rsv15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
      op_run("after_rsv", 4'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 1, 32'h000F_000F, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
